// File: rtl/matrix_mac_engine_pkg.sv
// Shared definitions for the matrix multiply-accumulate engine: FSM encodings and width helpers.
// Optional build macro MATMUL_SATURATE_EN (see matrix_mac_engine_mac_unit) changes only the stored result.
package matrix_mac_engine_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_WRITE = 2'd3;

   // Worst-case sum of MAX_LEN full-width products never overflows this width.
   function automatic int acc_width(input int data_width, input int max_len_log);
      return 2 * data_width + max_len_log;
   endfunction

endpackage

// File: rtl/matrix_mac_engine_if.sv
// Host, RAM and status bundle of matrix_mac_engine. Handshake: start is a request sampled only while busy=0;
// an accepted start raises busy on the same edge, and result_ready (level) rises on the edge busy falls.
interface matrix_mac_engine_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int MAX_LEN_LOG = 7
);
   logic                   start;
   logic [MAX_LEN_LOG-1:0] dim_m;
   logic [MAX_LEN_LOG-1:0] dim_k;
   logic [MAX_LEN_LOG-1:0] dim_n;
   logic [ADDR_WIDTH-1:0]  base_a;
   logic [ADDR_WIDTH-1:0]  base_b;
   logic [ADDR_WIDTH-1:0]  base_c;
   logic [ADDR_WIDTH-1:0]  host_addr;
   logic [DATA_WIDTH-1:0]  host_wdata;
   logic                   host_we;
   logic [DATA_WIDTH-1:0]  host_rdata;
   logic [ADDR_WIDTH-1:0]  mem_addr_a;
   logic [DATA_WIDTH-1:0]  mem_q_a;
   logic [ADDR_WIDTH-1:0]  mem_addr_b;
   logic [DATA_WIDTH-1:0]  mem_data_b;
   logic                   mem_we_b;
   logic [DATA_WIDTH-1:0]  mem_q_b;
   logic                   busy;
   logic                   result_ready;
   logic                   cfg_err;
   logic                   host_err;
   logic [1:0]             state_dbg;

   modport slave (
      input  start, dim_m, dim_k, dim_n, base_a, base_b, base_c,
      input  host_addr, host_wdata, host_we, mem_q_a, mem_q_b,
      output host_rdata, mem_addr_a, mem_addr_b, mem_data_b, mem_we_b,
      output busy, result_ready, cfg_err, host_err, state_dbg
   );

   modport master (
      output start, dim_m, dim_k, dim_n, base_a, base_b, base_c,
      output host_addr, host_wdata, host_we, mem_q_a, mem_q_b,
      input  host_rdata, mem_addr_a, mem_addr_b, mem_data_b, mem_we_b,
      input  busy, result_ready, cfg_err, host_err, state_dbg
   );
endinterface

// File: rtl/matrix_mac_engine_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and valid-gated accumulation.
// MATMUL_SATURATE_EN: result is the accumulator clamped to DATA_WIDTH; otherwise its low bits (wrap).
module matrix_mac_engine_mac_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ACC_WIDTH  = 71
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] result
);
   logic signed [2*DATA_WIDTH-1:0] a_ext;
   logic signed [2*DATA_WIDTH-1:0] b_ext;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic [ACC_WIDTH-1:0]           prod_ext;
   logic [ACC_WIDTH-1:0]           acc;

   assign a_ext    = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
   assign b_ext    = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
   assign prod     = a_ext * b_ext;
   assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc <= '0;
      end else if (valid) begin
         acc <= acc + prod_ext;
      end
   end

`ifdef MATMUL_SATURATE_EN
   logic fits;
   // The value fits when every bit from the result's sign bit upward agrees.
   assign fits   = (&acc[ACC_WIDTH-1:DATA_WIDTH-1]) | ~(|acc[ACC_WIDTH-1:DATA_WIDTH-1]);
   assign result = fits ? acc[DATA_WIDTH-1:0]
                 : (acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}});
`else
   assign result = acc[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/matrix_mac_engine.sv
// Runtime-sized signed matrix multiply C = A x B over a shared dual-port RAM; owns port B while busy.
// Build macro MATMUL_SATURATE_EN selects clamped instead of wrapped C elements.
module matrix_mac_engine
   import matrix_mac_engine_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 12,
   parameter int MAX_LEN     = 100,
   parameter int MAX_LEN_LOG = 7,
   parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, MAX_LEN_LOG)
) (
   input logic                 clk,
   input logic                 reset,
   matrix_mac_engine_if.slave  bus
);
   localparam logic [MAX_LEN_LOG-1:0] MAX_DIM = MAX_LEN_LOG'(MAX_LEN);
   localparam logic [MAX_LEN_LOG-1:0] ONE_D   = MAX_LEN_LOG'(1);
   localparam logic [ADDR_WIDTH-1:0]  ONE_A   = ADDR_WIDTH'(1);

   logic [1:0]             state;
   logic [MAX_LEN_LOG-1:0] m_r, k_r, n_r;
   logic [MAX_LEN_LOG-1:0] i_cnt, j_cnt, k_cnt;
   logic [ADDR_WIDTH-1:0]  row_a, ptr_a, col_b, ptr_b, ptr_c, base_b_r;
   logic                   valid_q;
   logic                   busy_r, result_ready_r, cfg_err_r, host_err_r;
   logic                   cfg_ok, accept, mac_clear;
   logic [ADDR_WIDTH-1:0]  k_ext, n_ext;
   logic [DATA_WIDTH-1:0]  mac_result;

   assign cfg_ok = (bus.dim_m != '0) && (bus.dim_m <= MAX_DIM) &&
                   (bus.dim_k != '0) && (bus.dim_k <= MAX_DIM) &&
                   (bus.dim_n != '0) && (bus.dim_n <= MAX_DIM);
   assign accept    = (state == ST_IDLE) && bus.start && cfg_ok;
   assign mac_clear = accept || (state == ST_WRITE);
   assign k_ext     = {{(ADDR_WIDTH-MAX_LEN_LOG){1'b0}}, k_r};
   assign n_ext     = {{(ADDR_WIDTH-MAX_LEN_LOG){1'b0}}, n_r};

   // Address pointers advance by adds only: A walks a row, B walks a column (stride N), C is contiguous.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         m_r            <= '0;
         k_r            <= '0;
         n_r            <= '0;
         i_cnt          <= '0;
         j_cnt          <= '0;
         k_cnt          <= '0;
         row_a          <= '0;
         ptr_a          <= '0;
         col_b          <= '0;
         ptr_b          <= '0;
         ptr_c          <= '0;
         base_b_r       <= '0;
         valid_q        <= 1'b0;
         busy_r         <= 1'b0;
         result_ready_r <= 1'b0;
         cfg_err_r      <= 1'b0;
         host_err_r     <= 1'b0;
      end else begin
         valid_q <= (state == ST_RUN);
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  result_ready_r <= 1'b0;
                  if (cfg_ok) begin
                     m_r        <= bus.dim_m;
                     k_r        <= bus.dim_k;
                     n_r        <= bus.dim_n;
                     i_cnt      <= '0;
                     j_cnt      <= '0;
                     k_cnt      <= '0;
                     row_a      <= bus.base_a;
                     ptr_a      <= bus.base_a;
                     col_b      <= bus.base_b;
                     ptr_b      <= bus.base_b;
                     base_b_r   <= bus.base_b;
                     ptr_c      <= bus.base_c;
                     busy_r     <= 1'b1;
                     cfg_err_r  <= 1'b0;
                     host_err_r <= 1'b0;
                     state      <= ST_RUN;
                  end else begin
                     cfg_err_r <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               ptr_a <= ptr_a + ONE_A;
               ptr_b <= ptr_b + n_ext;
               k_cnt <= k_cnt + ONE_D;
               if (k_cnt == k_r - ONE_D) state <= ST_DRAIN;
            end
            ST_DRAIN: state <= ST_WRITE;
            ST_WRITE: begin
               ptr_c <= ptr_c + ONE_A;
               k_cnt <= '0;
               if (j_cnt == n_r - ONE_D) begin
                  j_cnt <= '0;
                  row_a <= row_a + k_ext;
                  ptr_a <= row_a + k_ext;
                  col_b <= base_b_r;
                  ptr_b <= base_b_r;
                  if (i_cnt == m_r - ONE_D) begin
                     busy_r         <= 1'b0;
                     result_ready_r <= 1'b1;
                     state          <= ST_IDLE;
                  end else begin
                     i_cnt <= i_cnt + ONE_D;
                     state <= ST_RUN;
                  end
               end else begin
                  j_cnt <= j_cnt + ONE_D;
                  ptr_a <= row_a;
                  col_b <= col_b + ONE_A;
                  ptr_b <= col_b + ONE_A;
                  state <= ST_RUN;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (busy_r && bus.host_we) host_err_r <= 1'b1;
      end
   end

   matrix_mac_engine_mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clear  (mac_clear),
      .valid  (valid_q),
      .a      (bus.mem_q_a),
      .b      (bus.mem_q_b),
      .result (mac_result)
   );

   // Port B is the host's whenever the engine is idle.
   always_comb begin
      bus.mem_addr_a = ptr_a;
      bus.mem_addr_b = bus.host_addr;
      bus.mem_data_b = bus.host_wdata;
      bus.mem_we_b   = bus.host_we;
      bus.host_rdata = bus.mem_q_b;
      if (busy_r) begin
         bus.mem_addr_b = (state == ST_WRITE) ? ptr_c : ptr_b;
         bus.mem_data_b = mac_result;
         bus.mem_we_b   = (state == ST_WRITE);
         bus.host_rdata = '0;
      end
   end

   assign bus.busy         = busy_r;
   assign bus.result_ready = result_ready_r;
   assign bus.cfg_err      = cfg_err_r;
   assign bus.host_err     = host_err_r;
   assign bus.state_dbg    = state;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Directed and randomized bench for matrix_mac_engine; C is predicted from a memory image with plain arithmetic.
// Honours MATMUL_SATURATE_EN the same way the design does.
module tb_matrix_mac_engine;
   localparam int DW    = 32;
   localparam int AW    = 12;
   localparam int MLL   = 7;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   matrix_mac_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LEN_LOG(MLL)) bus ();

   matrix_mac_engine #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .MAX_LEN     (100),
      .MAX_LEN_LOG (MLL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Dual-port RAM with 1-cycle registered reads.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      bus.mem_q_a <= ram[bus.mem_addr_a];
      bus.mem_q_b <= ram[bus.mem_addr_b];
      if (bus.mem_we_b) ram[bus.mem_addr_b] <= bus.mem_data_b;
   end

   logic [DW-1:0] mirror [DEPTH];
   logic [DW-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] reduce(input logic signed [127:0] s);
      logic signed [127:0] hi, lo;
      hi = (128'sd1 <<< (DW - 1)) - 128'sd1;
      lo = -(128'sd1 <<< (DW - 1));
`ifdef MATMUL_SATURATE_EN
      if (s > hi) return hi[DW-1:0];
      if (s < lo) return lo[DW-1:0];
`endif
      return s[DW-1:0];
   endfunction

   task automatic host_write(input int addr, input logic [DW-1:0] d);
      @(posedge clk); #1;
      bus.host_addr  = AW'(addr);
      bus.host_wdata = d;
      bus.host_we    = 1'b1;
      @(posedge clk); #1;
      bus.host_we    = 1'b0;
      mirror[addr % DEPTH] = d;
   endtask

   task automatic load_words(input int base, input int cnt, input int kind);
      for (int w = 0; w < cnt; w++) begin
         int t;
         t = (kind == 0) ? int'($urandom) : int'($urandom_range(0, 15)) - 8;
         host_write((base + w) % DEPTH, t);
      end
   endtask

   task automatic start_pulse(input int m, input int k, input int n, input int ba, input int bb, input int bc);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.dim_m  = MLL'(m);
      bus.dim_k  = MLL'(k);
      bus.dim_n  = MLL'(n);
      bus.base_a = AW'(ba);
      bus.base_b = AW'(bb);
      bus.base_c = AW'(bc);
      @(posedge clk); #1;
      bus.start  = 1'b0;
   endtask

   task automatic run_mm(input int m, input int k, input int n, input int ba, input int bb, input int bc,
                         input bit disturb, input string tag);
      int cycles;
      int budget;
      for (int i = 0; i < m; i++) begin
         for (int j = 0; j < n; j++) begin
            logic signed [127:0] s, ae, be;
            logic [DW-1:0] av, bv;
            s = '0;
            for (int kk = 0; kk < k; kk++) begin
               av = mirror[(ba + i * k + kk) % DEPTH];
               bv = mirror[(bb + kk * n + j) % DEPTH];
               ae = {{(128-DW){av[DW-1]}}, av};
               be = {{(128-DW){bv[DW-1]}}, bv};
               s  = s + ae * be;
            end
            exp_q.push_back(reduce(s));
         end
      end
      start_pulse(m, k, n, ba, bb, bc);
      budget = m * n * (k + 2) + 50;
      cycles = 0;
      while (cycles < budget) begin
         @(negedge clk);
         if (!bus.busy) break;
         cycles++;
         if (disturb && cycles == 3) begin
            bus.host_addr  = AW'(12'hF00);
            bus.host_wdata = 32'hDEADBEEF;
            bus.host_we    = 1'b1;
            bus.start      = 1'b1;
            bus.dim_m      = MLL'(1);
            bus.dim_k      = MLL'(1);
            bus.dim_n      = MLL'(1);
         end
         if (disturb && cycles == 4) begin
            check({tag, "_busy_rdata"}, 64'(bus.host_rdata), 64'd0);
            bus.host_we = 1'b0;
            bus.start   = 1'b0;
         end
      end
      check({tag, "_busy_cycles"}, 64'(cycles), 64'(m * n * (k + 2)));
      check({tag, "_result_ready"}, 64'(bus.result_ready), 64'd1);
      check({tag, "_cfg_err"}, 64'(bus.cfg_err), 64'd0);
      check({tag, "_host_err"}, 64'(bus.host_err), 64'(disturb));
      for (int i = 0; i < m; i++) begin
         for (int j = 0; j < n; j++) begin
            int a;
            logic [DW-1:0] e;
            a = (bc + i * n + j) % DEPTH;
            e = exp_q.pop_front();
            check({tag, "_c"}, 64'(ram[a]), 64'(e));
            mirror[a] = e;
         end
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.dim_m = '0; bus.dim_k = '0; bus.dim_n = '0;
      bus.base_a = '0; bus.base_b = '0; bus.base_c = '0;
      bus.host_addr = '0; bus.host_wdata = '0; bus.host_we = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_result_ready", 64'(bus.result_ready), 64'd0);
      check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
      check("rst_host_err", 64'(bus.host_err), 64'd0);
      check("rst_mem_we_b", 64'(bus.mem_we_b), 64'd0);

      // Host path through port B while idle.
      host_write(12'hF00, 32'h12345678);
      @(posedge clk); #1 bus.host_addr = AW'(12'hF00);
      @(posedge clk);
      @(negedge clk);
      check("idle_host_rdata", 64'(bus.host_rdata), 64'h12345678);

      // 2x2x2 with B = identity.
      host_write(12'h000, 1); host_write(12'h001, 2); host_write(12'h002, 3); host_write(12'h003, 4);
      host_write(12'h010, 1); host_write(12'h011, 0); host_write(12'h012, 0); host_write(12'h013, 1);
      run_mm(2, 2, 2, 12'h000, 12'h010, 12'h100, 1'b0, "m2x2");
      for (int e = 0; e < 4; e++) check("m2x2_const", 64'(ram[12'h100 + e]), 64'(e + 1));

      host_write(12'h020, 1); host_write(12'h021, 2); host_write(12'h022, 3);
      host_write(12'h030, 4); host_write(12'h031, 5); host_write(12'h032, 6);
      run_mm(1, 3, 1, 12'h020, 12'h030, 12'h110, 1'b0, "dot3");
      check("dot3_const", 64'(ram[12'h110]), 64'd32);

      host_write(12'h040, 32'hFFFFFFFE); host_write(12'h041, 3);
      run_mm(1, 1, 1, 12'h040, 12'h041, 12'h111, 1'b0, "neg");
      check("neg_const", 64'(ram[12'h111]), 64'hFFFFFFFA);

      host_write(12'h042, 32'h7FFFFFFF); host_write(12'h043, 2);
      run_mm(1, 1, 1, 12'h042, 12'h043, 12'h112, 1'b0, "ovf");
`ifdef MATMUL_SATURATE_EN
      check("ovf_const", 64'(ram[12'h112]), 64'h7FFFFFFF);
`else
      check("ovf_const", 64'(ram[12'h112]), 64'hFFFFFFFE);
`endif

      // Rejected configurations.
      start_pulse(2, 0, 2, 12'h000, 12'h010, 12'h100);
      @(negedge clk);
      check("k0_cfg_err", 64'(bus.cfg_err), 64'd1);
      check("k0_busy", 64'(bus.busy), 64'd0);
      check("k0_result_ready", 64'(bus.result_ready), 64'd0);
      start_pulse(101, 2, 2, 12'h000, 12'h010, 12'h100);
      @(negedge clk);
      check("m101_cfg_err", 64'(bus.cfg_err), 64'd1);
      check("m101_busy", 64'(bus.busy), 64'd0);
      repeat (10) @(negedge clk);
      check("m101_busy_later", 64'(bus.busy), 64'd0);
      for (int e = 0; e < 4; e++) check("rej_ram", 64'(ram[12'h100 + e]), 64'(mirror[12'h100 + e]));

      // Host write and second start while busy.
      load_words(12'h200, 9, 1);
      load_words(12'h210, 9, 0);
      run_mm(3, 3, 3, 12'h200, 12'h210, 12'h220, 1'b1, "dist");
      check("dist_ram_kept", 64'(ram[12'hF00]), 64'(mirror[12'hF00]));

      // Reset in the middle of a 3x3x3 run, then a clean rerun.
      start_pulse(3, 3, 3, 12'h200, 12'h210, 12'h240);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_result_ready", 64'(bus.result_ready), 64'd0);
      check("midrst_host_err", 64'(bus.host_err), 64'd0);
      run_mm(3, 3, 3, 12'h200, 12'h210, 12'h240, 1'b0, "rerun");

      // C wraps past the top of the address space.
      load_words(12'h500, 6, 0);
      load_words(12'h510, 6, 1);
      run_mm(2, 3, 2, 12'h500, 12'h510, 12'hFFE, 1'b0, "wrap");

      // Largest inner dimension.
      load_words(12'h600, 100, 0);
      load_words(12'h700, 100, 0);
      run_mm(1, 100, 1, 12'h600, 12'h700, 12'h800, 1'b0, "kmax");

      for (int r = 0; r < 5; r++) begin
         int m, k, n;
         m = $urandom_range(1, 4);
         k = $urandom_range(1, 4);
         n = $urandom_range(1, 4);
         load_words(12'h900, m * k, r % 2);
         load_words(12'hA00, k * n, (r + 1) % 2);
         run_mm(m, k, n, 12'h900, 12'hA00, 12'hB00 + r * 16, 1'b0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
